// File: rtl/vending_pkg.sv
// Shared vending-machine definitions: amount width, coin values and the
// payout controller state encoding.
package vending_pkg;

  localparam int AMT_W_DEF = 3;
  localparam int COIN1_VAL = 1;
  localparam int COIN2_VAL = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_DRIVE2 = 3'd2,
    ST_DRIVE1 = 3'd3,
    ST_GAP    = 3'd4,
    ST_DONE   = 3'd5
  } pay_state_e;

endpackage

// File: rtl/payout_timer.sv
// Hopper drive timeout counter. Cleared before each drive, counts while
// enabled, and raises tc on the last allowed drive cycle so the drive is
// high for exactly TIMEOUT_CYC cycles.
module payout_timer #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tc = (cnt_q == LAST);

  // Next count: clear wins, saturate at terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)           cnt_d = '0;
    else if (en && !tc) cnt_d = cnt_q + CW'(1);
  end

  // Count register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/coin_payout_ctrl.sv
// Coin payout controller: pays a requested amount greedily from the value-2
// and value-1 hoppers, one coin at a time, with a drive/sense handshake and
// per-hopper jam detection. Reports paid/short totals and a fault flag.
module coin_payout_ctrl
  import vending_pkg::*;
#(
  parameter int AMT_W       = AMT_W_DEF,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [AMT_W-1:0] req_amount,
  input  logic             req_is_refund,
  output logic             req_ready,
  input  logic             hop1_empty,
  input  logic             hop2_empty,
  input  logic             hop1_sense,
  input  logic             hop2_sense,
  output logic             hop1_drive,
  output logic             hop2_drive,
  output logic             busy,
  output logic             done,
  output logic             done_is_refund,
  output logic [AMT_W-1:0] paid,
  output logic [AMT_W-1:0] short_amt,
  output logic             fault
);

  localparam logic [AMT_W-1:0] C1 = AMT_W'(COIN1_VAL);
  localparam logic [AMT_W-1:0] C2 = AMT_W'(COIN2_VAL);

  pay_state_e       state_q, state_d;
  logic [AMT_W-1:0] remain_q, remain_d;
  logic [AMT_W-1:0] paid_q, paid_d;
  logic [AMT_W-1:0] short_q, short_d;
  logic             fault_q, fault_d;
  logic             jam1_q, jam1_d;
  logic             jam2_q, jam2_d;
  logic             refund_q, refund_d;
  logic             tmr_clr, tmr_en, tmr_tc;

  payout_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (tmr_clr),
    .en  (tmr_en),
    .tc  (tmr_tc)
  );

  // Moore outputs decoded straight from the state register, so an async
  // reset drops the hopper drives immediately.
  assign hop2_drive     = (state_q == ST_DRIVE2);
  assign hop1_drive     = (state_q == ST_DRIVE1);
  assign req_ready      = (state_q == ST_IDLE);
  assign busy           = !req_ready;
  assign done           = (state_q == ST_DONE);
  assign done_is_refund = refund_q;
  assign paid           = paid_q;
  assign short_amt      = short_q;
  assign fault          = fault_q;

  // Next-state and datapath updates for the payout sequence.
  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    paid_d   = paid_q;
    short_d  = short_q;
    fault_d  = fault_q;
    jam1_d   = jam1_q;
    jam2_d   = jam2_q;
    refund_d = refund_q;
    tmr_clr  = 1'b0;
    tmr_en   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          remain_d = req_amount;
          refund_d = req_is_refund;
          paid_d   = '0;
          short_d  = '0;
          fault_d  = 1'b0;
          jam1_d   = 1'b0;
          jam2_d   = 1'b0;
          state_d  = ST_SELECT;
        end
      end
      ST_SELECT: begin
        // Timer is cleared here so it starts at zero on drive entry.
        tmr_clr = 1'b1;
        if (remain_q >= C2 && !hop2_empty && !jam2_q)      state_d = ST_DRIVE2;
        else if (remain_q >= C1 && !hop1_empty && !jam1_q) state_d = ST_DRIVE1;
        else begin
          short_d = remain_q;
          state_d = ST_DONE;
        end
      end
      ST_DRIVE2: begin
        tmr_en = 1'b1;
        if (hop2_sense) begin
          remain_d = remain_q - C2;
          paid_d   = paid_q + C2;
          state_d  = ST_GAP;
        end else if (tmr_tc) begin
          jam2_d  = 1'b1;
          fault_d = 1'b1;
          state_d = ST_GAP;
        end
      end
      ST_DRIVE1: begin
        tmr_en = 1'b1;
        if (hop1_sense) begin
          remain_d = remain_q - C1;
          paid_d   = paid_q + C1;
          state_d  = ST_GAP;
        end else if (tmr_tc) begin
          jam1_d  = 1'b1;
          fault_d = 1'b1;
          state_d = ST_GAP;
        end
      end
      ST_GAP:  state_d = ST_SELECT;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      remain_q <= '0;
      paid_q   <= '0;
      short_q  <= '0;
      fault_q  <= 1'b0;
      jam1_q   <= 1'b0;
      jam2_q   <= 1'b0;
      refund_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      paid_q   <= paid_d;
      short_q  <= short_d;
      fault_q  <= fault_d;
      jam1_q   <= jam1_d;
      jam2_q   <= jam2_d;
      refund_q <= refund_d;
    end
  end

endmodule

// File: tb/tb_coin_payout_ctrl.sv
// Bench for coin_payout_ctrl: table of payout scenarios with a behavioural
// hopper model, a scoreboard of expected completions, and hand-written
// reset-during-payout sequence.
module tb_coin_payout_ctrl;

  localparam int AMT_W = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             req_valid = 1'b0;
  logic [AMT_W-1:0] req_amount = '0;
  logic             req_is_refund = 1'b0;
  logic             req_ready;
  logic             hop1_empty = 1'b0, hop2_empty = 1'b0;
  logic             hop1_sense = 1'b0, hop2_sense = 1'b0;
  logic             hop1_drive, hop2_drive;
  logic             busy, done, done_is_refund, fault;
  logic [AMT_W-1:0] paid, short_amt;

  always #5 clk = ~clk;

  coin_payout_ctrl #(.AMT_W(AMT_W), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_amount(req_amount), .req_is_refund(req_is_refund),
    .req_ready(req_ready),
    .hop1_empty(hop1_empty), .hop2_empty(hop2_empty),
    .hop1_sense(hop1_sense), .hop2_sense(hop2_sense),
    .hop1_drive(hop1_drive), .hop2_drive(hop2_drive),
    .busy(busy), .done(done), .done_is_refund(done_is_refund),
    .paid(paid), .short_amt(short_amt), .fault(fault)
  );

  typedef struct {
    int amt; int refund; int e1; int e2; int en2;
    int noise; int empty_mid; int poke;
    int x_paid; int x_short; int x_fault; int x_n2; int x_n1; int x_len2; int x_cyc;
  } vec_t;

  typedef struct { int paid; int short_amt; int fault; int refund; } exp_t;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  vec_t vt[9];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Apply one table entry: request, hopper model, scoreboard compare at done.
  task automatic run_vec(input int idx, input vec_t v);
    int n1, n2, run2, len2, done_cyc;
    logic p1, p2;
    exp_t e;
    n1 = 0; n2 = 0; run2 = 0; len2 = 0; done_cyc = -1; p1 = 0; p2 = 0;
    hop1_empty = v.e1[0]; hop2_empty = v.e2[0];
    e.paid = v.x_paid; e.short_amt = v.x_short; e.fault = v.x_fault; e.refund = v.refund;
    @(negedge clk);
    chk($sformatf("v%0d ready_before", idx), int'(req_ready), 1);
    req_valid = 1'b1; req_amount = AMT_W'(v.amt); req_is_refund = v.refund[0];
    sb.push_back(e);
    @(posedge clk);
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      req_valid = (v.poke != 0) && (c == 2 || c == 3);
      req_amount = (v.poke != 0) ? 3'd7 : 3'd0;
      if (hop2_drive && !p2) n2++;
      if (hop1_drive && !p1) n1++;
      if (hop2_drive) run2++;
      else begin
        if (run2 > len2) len2 = run2;
        run2 = 0;
      end
      p1 = hop1_drive; p2 = hop2_drive;
      if (hop2_drive && v.empty_mid != 0) hop2_empty = 1'b1;
      hop2_sense = hop2_drive && (v.en2 != 0);
      hop1_sense = hop1_drive || ((v.noise != 0) && hop2_drive);
      if (done) begin
        done_cyc = c;
        break;
      end
    end
    hop1_sense = 1'b0; hop2_sense = 1'b0; req_valid = 1'b0;
    chk($sformatf("v%0d done_seen", idx), int'(done_cyc >= 0), 1);
    if (done_cyc >= 0) begin
      if (sb.size() == 0) chk($sformatf("v%0d sb_nonempty", idx), 0, 1);
      else begin
        e = sb.pop_front();
        chk($sformatf("v%0d paid", idx), int'(paid), e.paid);
        chk($sformatf("v%0d short", idx), int'(short_amt), e.short_amt);
        chk($sformatf("v%0d fault", idx), int'(fault), e.fault);
        chk($sformatf("v%0d refund", idx), int'(done_is_refund), e.refund);
      end
      chk($sformatf("v%0d paid+short", idx), int'(paid) + int'(short_amt), v.amt);
      if (v.x_cyc >= 0) chk($sformatf("v%0d done_cycle", idx), done_cyc, v.x_cyc);
    end
    chk($sformatf("v%0d n2", idx), n2, v.x_n2);
    chk($sformatf("v%0d n1", idx), n1, v.x_n1);
    if (v.x_n2 > 0) chk($sformatf("v%0d len2", idx), len2, v.x_len2);
    // Totals hold, controller idle, stray request during busy not queued.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("v%0d idle_ready", idx), int'(req_ready), 1);
      chk($sformatf("v%0d idle_done", idx), int'(done), 0);
      chk($sformatf("v%0d hold_paid", idx), int'(paid), v.x_paid);
    end
  endtask

  initial begin
    //           amt ref e1 e2 en2 noi emid poke paid shrt flt n2 n1 len2 cyc
    vt[0] = '{5, 0, 0, 0, 1, 1, 0, 0, 5, 0, 0, 2, 1, 1, 10};
    vt[1] = '{4, 1, 0, 1, 1, 0, 0, 0, 4, 0, 0, 0, 4, 0, 13};
    vt[2] = '{3, 0, 0, 0, 0, 0, 0, 0, 3, 0, 1, 1, 3, 16, 28};
    vt[3] = '{3, 0, 1, 1, 1, 0, 0, 0, 0, 3, 0, 0, 0, 0, -1};
    vt[4] = '{0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    vt[5] = '{2, 0, 0, 0, 1, 0, 0, 0, 2, 0, 0, 1, 0, 1, 4};
    vt[6] = '{3, 0, 0, 0, 1, 0, 1, 0, 3, 0, 0, 1, 1, 1, 7};
    vt[7] = '{7, 0, 1, 0, 1, 0, 0, 1, 6, 1, 0, 3, 0, 1, 10};
    vt[8] = '{6, 1, 1, 0, 0, 0, 0, 0, 0, 6, 1, 1, 0, 16, 19};

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_ready", int'(req_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_drive", int'(hop1_drive | hop2_drive), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_totals", int'(paid) + int'(short_amt) + int'(fault) + int'(done_is_refund), 0);
    rst = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(i, vt[i]);

    // Reset mid-DRIVE2: hopper 2 never senses, pull reset while driving.
    hop1_empty = 1'b0; hop2_empty = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_amount = 3'd2; req_is_refund = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_drive2_on", int'(hop2_drive), 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_drive", int'(hop2_drive), 0);
    chk("mid_rst_ready", int'(req_ready), 1);
    chk("mid_rst_busy", int'(busy), 0);
    @(negedge clk);
    chk("mid_rst_paid", int'(paid), 0);
    chk("mid_rst_refund", int'(done_is_refund), 0);
    rst = 1'b1;
    run_vec(9, vt[5]);

    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
